issue_unit: RTL
===============

Name: issue_unit

Overview:
- Consumer side of the four dispatch execution queues: integer, load/store, multiply and divide.
- Each cycle it selects at most one queue head whose operands are ready and pops it with a one-cycle read-enable pulse.
- It tracks execution-unit occupancy and books the single shared common data bus (CDB) ahead of time, so two results never collide on the bus.
- It sits between the exec FIFOs and the functional units. Its CDB owner outputs steer the writeback mux.

Parameters:
- INT_LAT, 1: integer unit latency, issue cycle to CDB cycle.
- LDST_LAT, 2: load/store unit latency. Fixed, no miss handling.
- MULT_LAT, 4: multiplier latency. The multiplier is fully pipelined.
- DIV_LAT, 8: divider latency. The divider is non-pipelined. DIV_LAT must be the largest latency, and every latency must be at least 1.

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_int_empty  in  1  integer queue empty
- i_int_ready  in  1  integer queue head has all operands ready
- o_int_rd_en  out  1  pop integer queue head (combinational grant)
- i_ldst_empty  in  1  load/store queue empty
- i_ldst_ready  in  1  load/store queue head operands ready
- o_ldst_rd_en  out  1  pop load/store queue head
- i_mult_empty  in  1  multiply queue empty
- i_mult_ready  in  1  multiply queue head operands ready
- o_mult_rd_en  out  1  pop multiply queue head
- i_div_empty  in  1  divide queue empty
- i_div_ready  in  1  divide queue head operands ready
- o_div_rd_en  out  1  pop divide queue head
- o_issue_valid  out  1  an issue happens this cycle (OR of the four rd_en signals)
- o_issue_unit  out  2  issued unit: 00 int, 01 ldst, 10 mult, 11 div. Holds 00 when o_issue_valid=0.
- o_cdb_valid  out  1  a booked result drives the CDB this cycle (registered)
- o_cdb_unit  out  2  owner of the CDB this cycle (registered; 00 when o_cdb_valid=0)
- o_div_busy  out  1  divider occupied (registered)

Behaviour:
- Reset (i_rst=1 at an edge): the reservation table, owner tags, divider counter and round-robin pointer all clear. The pointer resets to int as highest priority.
  - After reset: o_cdb_valid=0, o_cdb_unit=00, o_div_busy=0.
  - Combinational outputs are 0 while i_rst=1, so no pops happen during reset.
  - A reset mid-operation discards all bookings and makes the divider free on the next cycle.
- Reservation table, entries R[0..DIV_LAT], each a valid bit plus a 2-bit owner:
  - R[k] describes the cycle k cycles from now.
  - o_cdb_valid and o_cdb_unit are R[0].
  - At each edge, R[k] takes R[k+1] for k<DIV_LAT, and R[DIV_LAT] is cleared.
  - An issue of unit X with latency L sets R[L-1] with owner X. Its result therefore drives the CDB exactly L cycles after the rd_en cycle.
- Eligibility of unit X, all conditions required:
  - !empty_X and ready_X;
  - R[L_X].valid==0;
  - for div only, additionally the divider counter is 0.
- A head that is not ready blocks only its own queue. Each queue issues in order.
- Arbitration is round-robin in the order int, ldst, mult, div. The search starts one after the last granted unit.
  - At most one grant per cycle.
  - The pointer advances only on a grant; with no grant, the pointer holds.
- Divider counter:
  - Loaded with DIV_LAT-1 on a div issue edge, otherwise decrements while nonzero.
  - o_div_busy = (counter != 0).
  - The next div can issue no earlier than DIV_LAT cycles after the previous one.
- The multiplier is pipelined: back-to-back mult issues are allowed, subject only to CDB booking.
- Latency: grant to rd_en is 0 cycles (same cycle). rd_en to CDB is L cycles.

Test Plan:
- Reset: drive i_rst=1 for 2 cycles with all queues nonempty and ready -> every rd_en=0 while reset is high; o_cdb_valid=0 and o_div_busy=0 after reset.
- Single int: int nonempty and ready at cycle 0 -> o_int_rd_en=1 and o_issue_unit=00 at cycle 0; o_cdb_valid=1 with o_cdb_unit=00 at cycle 1 only.
- CDB conflict:
  - Stimulus: mult issues at cycle 0, booking cycle 4; at cycle 2 only ldst is ready.
  - Required: ldst is blocked at cycle 2 (R[2] busy) and issues at cycle 3.
  - CDB owner: mult at cycle 4, ldst at cycle 5.
- Divider occupancy: two ready div heads, div issued at cycle 0 -> o_div_busy=1 for cycles 1-7; second o_div_rd_en at cycle 8; CDB owner 11 at cycles 8 and 16.
- Round-robin: all four queues always nonempty and ready, starting from reset.
  - Required grants: c0 int, c1 ldst, c2 mult, c3 div, c4 int, c5 ldst, c6 mult.
  - c7: int, because the divider is busy.
  - No CDB cycle ever has two owners.
- Reset mid-operation: assert i_rst at cycle 3 after a div issue at cycle 0 and a mult issue at cycle 1 -> at cycle 4 o_cdb_valid=0 and o_div_busy=0; a ready div head is granted at cycle 4 and no stale CDB valid appears at cycle 5 or cycle 8.

Source files
------------

// File: rtl/issue_unit.sv
// Issue stage: picks at most one ready exec-queue head per cycle (round-robin),
// books the shared CDB slot in a reservation table and tracks divider occupancy.
module issue_unit #(
    parameter int INT_LAT  = 1,
    parameter int LDST_LAT = 2,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_int_empty,
    input  logic       i_int_ready,
    output logic       o_int_rd_en,
    input  logic       i_ldst_empty,
    input  logic       i_ldst_ready,
    output logic       o_ldst_rd_en,
    input  logic       i_mult_empty,
    input  logic       i_mult_ready,
    output logic       o_mult_rd_en,
    input  logic       i_div_empty,
    input  logic       i_div_ready,
    output logic       o_div_rd_en,
    output logic       o_issue_valid,
    output logic [1:0] o_issue_unit,
    output logic       o_cdb_valid,
    output logic [1:0] o_cdb_unit,
    output logic       o_div_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    localparam logic [1:0] U_INT  = 2'd0;
    localparam logic [1:0] U_LDST = 2'd1;
    localparam logic [1:0] U_MULT = 2'd2;
    localparam logic [1:0] U_DIV  = 2'd3;

    logic [DIV_LAT:0] r_rsv_vld;
    logic [1:0]       r_rsv_own [0:DIV_LAT];
    logic [CW-1:0]    r_div_cnt;
    logic [1:0]       r_last;

    logic [3:0] w_elig;
    logic       w_grant_ok;
    logic [1:0] w_grant_unit;
    logic [1:0] w_idx;

    // A unit is eligible when its head is ready and the CDB slot its result would hit is free.
    always_comb begin
        w_elig    = 4'b0000;
        w_elig[0] = !i_rst && !i_int_empty  && i_int_ready  && !r_rsv_vld[INT_LAT];
        w_elig[1] = !i_rst && !i_ldst_empty && i_ldst_ready && !r_rsv_vld[LDST_LAT];
        w_elig[2] = !i_rst && !i_mult_empty && i_mult_ready && !r_rsv_vld[MULT_LAT];
        w_elig[3] = !i_rst && !i_div_empty  && i_div_ready  && !r_rsv_vld[DIV_LAT]
                    && (r_div_cnt == {CW{1'b0}});
    end

    // Round-robin search starting one past the last granted unit.
    always_comb begin
        w_grant_ok   = 1'b0;
        w_grant_unit = 2'b00;
        w_idx        = 2'b00;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_last + 2'(i + 1);
            if (!w_grant_ok && w_elig[w_idx]) begin
                w_grant_ok   = 1'b1;
                w_grant_unit = w_idx;
            end else begin
                w_grant_ok   = w_grant_ok;
                w_grant_unit = w_grant_unit;
            end
        end
    end

    // Decode the single grant into queue pops and issue status.
    always_comb begin
        o_int_rd_en   = w_grant_ok && (w_grant_unit == U_INT);
        o_ldst_rd_en  = w_grant_ok && (w_grant_unit == U_LDST);
        o_mult_rd_en  = w_grant_ok && (w_grant_unit == U_MULT);
        o_div_rd_en   = w_grant_ok && (w_grant_unit == U_DIV);
        o_issue_valid = w_grant_ok;
        if (w_grant_ok) begin
            o_issue_unit = w_grant_unit;
        end else begin
            o_issue_unit = 2'b00;
        end
    end

    // Reservation table: shift one slot per cycle and book the slot of a new issue.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsv_vld <= '0;
            for (int k = 0; k <= DIV_LAT; k++) begin
                r_rsv_own[k] <= 2'b00;
            end
        end else begin
            for (int k = 0; k < DIV_LAT; k++) begin
                r_rsv_vld[k] <= r_rsv_vld[k+1];
                r_rsv_own[k] <= r_rsv_own[k+1];
            end
            r_rsv_vld[DIV_LAT] <= 1'b0;
            r_rsv_own[DIV_LAT] <= 2'b00;
            if (w_grant_ok) begin
                case (w_grant_unit)
                    U_INT: begin
                        r_rsv_vld[INT_LAT-1] <= 1'b1;
                        r_rsv_own[INT_LAT-1] <= U_INT;
                    end
                    U_LDST: begin
                        r_rsv_vld[LDST_LAT-1] <= 1'b1;
                        r_rsv_own[LDST_LAT-1] <= U_LDST;
                    end
                    U_MULT: begin
                        r_rsv_vld[MULT_LAT-1] <= 1'b1;
                        r_rsv_own[MULT_LAT-1] <= U_MULT;
                    end
                    U_DIV: begin
                        r_rsv_vld[DIV_LAT-1] <= 1'b1;
                        r_rsv_own[DIV_LAT-1] <= U_DIV;
                    end
                    default: begin
                        r_rsv_vld[0] <= r_rsv_vld[1];
                    end
                endcase
            end else begin
                r_rsv_vld[DIV_LAT] <= 1'b0;
            end
        end
    end

    // Divider occupancy counter and round-robin pointer (reset leaves int at top priority).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= {CW{1'b0}};
            r_last    <= U_DIV;
        end else begin
            if (w_grant_ok && (w_grant_unit == U_DIV)) begin
                r_div_cnt <= CW'(DIV_LAT - 1);
            end else if (r_div_cnt != {CW{1'b0}}) begin
                r_div_cnt <= r_div_cnt - CW'(1);
            end else begin
                r_div_cnt <= r_div_cnt;
            end
            if (w_grant_ok) begin
                r_last <= w_grant_unit;
            end else begin
                r_last <= r_last;
            end
        end
    end

    assign o_cdb_valid = r_rsv_vld[0];
    assign o_cdb_unit  = r_rsv_own[0];
    assign o_div_busy  = (r_div_cnt != {CW{1'b0}});

endmodule
